// File: rtl/id_pipe_reg.sv
// id_pipe_reg: IF/ID pipeline register with a one-entry skid buffer and load-use hazard detection.
module id_pipe_reg #(
    parameter int               WIDTH   = 32,
    parameter int               NFIELDS = 3,
    parameter int               REGW    = 5,
    parameter logic [WIDTH-1:0] NOP     = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WIDTH*NFIELDS-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH*NFIELDS-1:0] out_data,
    input  logic                     out_ready,
    input  logic                     flush,
    input  logic                     ex_memread,
    input  logic [REGW-1:0]          ex_rd,
    input  logic [REGW-1:0]          id_rs1,
    input  logic [REGW-1:0]          id_rs2,
    output logic                     hazard_stall,
    output logic [15:0]              bubble_count
);
    localparam int DW = WIDTH * NFIELDS;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t          r_state, w_next;
    logic [DW-1:0]   r_main, r_skid, w_nop;
    logic            r_in_ready, r_out_valid, w_accept, w_consume, w_hazard;
    logic [15:0]     r_bubble;
    assign w_nop        = {NFIELDS{NOP}};
    assign w_hazard     = r_out_valid & ex_memread & (ex_rd != '0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign w_accept     = in_valid & r_in_ready;
    assign w_consume    = r_out_valid & out_ready & ~w_hazard;
    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_main;
    assign hazard_stall = w_hazard;
    assign bubble_count = r_bubble;
    always_comb begin
        w_next = r_state;
        case (r_state)
            EMPTY:   w_next = w_accept ? ONE : EMPTY;
            ONE:     w_next = (w_accept && !w_consume) ? FULL : (!w_accept && w_consume) ? EMPTY : ONE;
            FULL:    w_next = w_consume ? ONE : FULL;
            default: w_next = EMPTY;
        endcase
        if (flush) w_next = EMPTY;
    end
    // main is reloaded with NOP whenever it empties so out_data reads NOP while invalid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_main      <= w_nop;
            r_skid      <= w_nop;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_bubble    <= '0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next != FULL);
            r_out_valid <= (w_next != EMPTY);
            if (w_hazard && r_bubble != 16'hFFFF) r_bubble <= r_bubble + 16'd1;
            if (flush) begin
                r_main <= w_nop;
                r_skid <= w_nop;
            end else begin
                case (r_state)
                    EMPTY: if (w_accept) r_main <= in_data;
                    ONE: begin
                        if (w_accept && w_consume) r_main <= in_data;
                        else if (w_accept) r_skid <= in_data;
                        else if (w_consume) r_main <= w_nop;
                    end
                    FULL: if (w_consume) begin
                        r_main <= r_skid;
                        r_skid <= w_nop;
                    end
                    default: begin
                        r_main <= w_nop;
                        r_skid <= w_nop;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/id_pipe_reg.md
ID_PIPE_REG -- requirements
Module: id_pipe_reg

Interface
REQ-001 Parameter WIDTH, 32, bit width of one field.
REQ-002 Parameter NFIELDS, 3, number of fields carried; field 0 = instruction, field 1 = delay (PC+4), field 2 = delay2 (PC+8).
REQ-003 Parameter REGW, 5, register-index width.
REQ-004 Parameter NOP, 0, WIDTH-bit value loaded into every field on bubble, flush or reset.
REQ-005 clk  in  1  single clock; all state changes on posedge clk.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  upstream (fetch) presents in_data.
REQ-008 in_data  in  WIDTH*NFIELDS  packed fields, field k at bits [k*WIDTH +: WIDTH].
REQ-009 in_ready  out  1  stage can accept; registered output.
REQ-010 out_valid  out  1  out_data holds a live instruction.
REQ-011 out_data  out  WIDTH*NFIELDS  fields presented to decode.
REQ-012 out_ready  in  1  downstream (EX) can accept.
REQ-013 flush  in  1  taken branch/jump; kills all held and incoming entries.
REQ-014 ex_memread  in  1  instruction currently in EX is a load.
REQ-015 ex_rd  in  REGW  destination register of the EX instruction.
REQ-016 id_rs1, id_rs2  in  REGW each  source registers decoded from out_data field 0.
REQ-017 hazard_stall  out  1  load-use stall this cycle (combinational).
REQ-018 bubble_count  out  16  saturating count of load-use stall cycles.

Function
REQ-019 Storage SHALL be a main register (drives out_data) plus one skid register, with states EMPTY (neither valid), ONE (main valid), FULL (both valid).
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL.
REQ-021 accept = in_valid & in_ready; consume = out_valid & out_ready & ~hazard_stall.
REQ-022 hazard_stall SHALL = out_valid & ex_memread & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-023 EMPTY: accept -> ONE, main <= in_data; else stay EMPTY.
REQ-024 ONE: accept & consume -> ONE, main <= in_data; accept & ~consume -> FULL, skid <= in_data; ~accept & consume -> EMPTY; neither -> ONE, main held.
REQ-025 FULL: consume -> ONE, main <= skid; else hold both.
REQ-026 Latency in_data to out_data SHALL be exactly 1 cycle when the stage is EMPTY or consumed in the same cycle; order of entries SHALL be preserved.
REQ-027 When out_valid = 0, out_data SHALL equal NOP in every field.
REQ-028 flush SHALL take priority over every other event: next state EMPTY, main and skid loaded with NOP, any same-cycle accept discarded, in_ready = 1 next cycle.
REQ-029 flush and hazard_stall in the same cycle: flush wins; bubble_count still increments.
REQ-030 bubble_count SHALL increment by 1 each cycle hazard_stall = 1 and saturate at 16'hFFFF without wrap.
REQ-031 hazard_stall SHALL not depend on in_valid or out_ready; a stalled entry stays in main unchanged.
REQ-032 ex_rd = 0 SHALL never raise hazard_stall.

Reset
REQ-033 On clk edge with reset = 1: state EMPTY, main and skid = NOP, out_valid = 0, in_ready = 1, bubble_count = 0; reset overrides flush and accept.
REQ-034 reset asserted mid-operation (FULL) SHALL discard both entries with no output transfer that cycle.

Verification
REQ-035 Streaming: in_valid = 1, out_ready = 1, in_data field0 = 0x8C010004, 0x00221820, ... -> each appears on out_data one cycle later, out_valid = 1 continuously, in_ready stays 1.
REQ-036 Backpressure: out_ready = 0 with two accepts -> state FULL, in_ready = 0 on 3rd cycle; out_ready = 1 -> entries emerge in order, in_ready = 1 after first consume.
REQ-037 Load-use: ex_memread = 1, ex_rd = 1, id_rs1 = 1 -> hazard_stall = 1, out_data held, bubble_count 0 -> 1; ex_rd = 0 same stimulus -> hazard_stall = 0.
REQ-038 Flush in FULL with in_valid = 1 -> next cycle out_valid = 0, out_data = NOP, in_ready = 1, incoming entry never appears.
REQ-039 Saturation: force 65 540 stall cycles -> bubble_count = 16'hFFFF and remains.
REQ-040 Reset while FULL and flush = 1 -> next cycle EMPTY, all outputs at reset values, bubble_count = 0.
